instruction_fetch_sequencer: RTL and testbench

- Drives the byte-wide instruction memory and the byte-loaded 16-bit instruction register.
- On a fetch request it reads two consecutive bytes at PC: low byte first, then high byte.
- For each byte it generates the register's byte-select (LH) and Write strobes, and advances PC by one per byte.
- Sits between the control unit (Start/Done handshake) and the memory/instruction-register pair.

---
 rtl/instruction_fetch_sequencer_pkg.sv | 20 ++
 rtl/fetch_pc_counter.sv | 41 ++++
 rtl/instruction_fetch_sequencer.sv | 125 ++++++++++++
 tb/tb_instruction_fetch_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer_pkg
// Shared definitions for the instruction fetch path.
//   fetch_state_t : 3-bit fetch sequencer state encoding
//   LH_LOW/LH_HIGH: byte-select encodings shared with the instruction register
// -----------------------------------------------------------------------------
package instruction_fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH_IDLE    = 3'd0,
        FETCH_LO_ADDR = 3'd1,
        FETCH_LO_CAP  = 3'd2,
        FETCH_HI_ADDR = 3'd3,
        FETCH_HI_CAP  = 3'd4
    } fetch_state_t;

    localparam logic LH_LOW  = 1'b0;
    localparam logic LH_HIGH = 1'b1;

endpackage

// File: rtl/fetch_pc_counter.sv
// -----------------------------------------------------------------------------
// fetch_pc_counter
// Program counter register for the fetch sequencer.
// Ports:
//   clock  : system clock
//   reset  : asynchronous active-high reset, PC goes to RESET_PC
//   hold   : freezes the PC (takes priority over load and inc)
//   load   : synchronous load of pc_in
//   inc    : synchronous increment, wraps modulo 2^ADDR_WIDTH
//   pc_in  : value to load
//   pc     : current PC
// -----------------------------------------------------------------------------
module fetch_pc_counter
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  hold,
    input  logic                  load,
    input  logic                  inc,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    output logic [ADDR_WIDTH-1:0] pc
);

    // Load wins over increment; the sequencer never requests both at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (!hold) begin
            if (load) begin
                pc <= pc_in;
            end else if (inc) begin
                pc <= pc + ADDR_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instruction_fetch_sequencer
// Fetches a 16-bit instruction as two bytes (low then high) from a byte-wide
// memory and writes them into a byte-loaded instruction register.
// Ports:
//   Clock, Reset          : system clock, asynchronous active-high reset
//   Start                 : fetch request (sampled in IDLE and HI_CAP)
//   Stall                 : freezes state, wait counter and PC
//   PCLoad, PCIn          : PC load, honoured only in IDLE
//   MemData               : byte returned by memory, MEM_LATENCY cycles after address
//   MemAddr, MemRead      : memory read address and enable
//   IRByte, IR_LH, IR_Write : instruction register byte, byte select, write strobe
//   Busy, Done            : not-idle indicator, high-byte-written pulse
//   PCOut                 : current PC
// -----------------------------------------------------------------------------
module instruction_fetch_sequencer
    import instruction_fetch_sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    MEM_LATENCY = 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Stall,
    input  logic                  PCLoad,
    input  logic [ADDR_WIDTH-1:0] PCIn,
    input  logic [7:0]            MemData,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic                  MemRead,
    output logic [7:0]            IRByte,
    output logic                  IR_LH,
    output logic                  IR_Write,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH-1:0] PCOut
);

    fetch_state_t          state;
    logic [2:0]            wait_cnt;
    logic                  wait_done;
    logic                  cap_state;
    logic                  pc_load;
    logic                  pc_inc;
    logic [ADDR_WIDTH-1:0] pc;

    assign wait_done = (wait_cnt == 3'(MEM_LATENCY - 1));
    assign cap_state = (state == FETCH_LO_CAP) || (state == FETCH_HI_CAP);

    // A load in IDLE coincident with Start lands before the first address
    // cycle, so the new fetch naturally reads from PCIn.
    assign pc_load = (state == FETCH_IDLE) && PCLoad;
    assign pc_inc  = cap_state;

    fetch_pc_counter #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RESET_PC  (RESET_PC)
    ) u_pc (
        .clock(Clock),
        .reset(Reset),
        .hold (Stall),
        .load (pc_load),
        .inc  (pc_inc),
        .pc_in(PCIn),
        .pc   (pc)
    );

    // Stall holds everything, so a stalled CAP state simply repeats and its
    // byte is written once, in the first unstalled cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= FETCH_IDLE;
            wait_cnt <= '0;
        end else if (!Stall) begin
            case (state)
                FETCH_IDLE: begin
                    if (Start) begin
                        state    <= FETCH_LO_ADDR;
                        wait_cnt <= '0;
                    end
                end
                FETCH_LO_ADDR: begin
                    if (wait_done) begin
                        state    <= FETCH_LO_CAP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                FETCH_LO_CAP: begin
                    state    <= FETCH_HI_ADDR;
                    wait_cnt <= '0;
                end
                FETCH_HI_ADDR: begin
                    if (wait_done) begin
                        state    <= FETCH_HI_CAP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                FETCH_HI_CAP: begin
                    state    <= Start ? FETCH_LO_ADDR : FETCH_IDLE;
                    wait_cnt <= '0;
                end
                default: begin
                    state    <= FETCH_IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // MemAddr tracks PC in every state, which also gives RESET_PC in reset.
    assign MemAddr  = pc;
    assign PCOut    = pc;
    assign MemRead  = (state != FETCH_IDLE);
    assign Busy     = (state != FETCH_IDLE);
    assign IRByte   = cap_state ? MemData : 8'h00;
    assign IR_LH    = (state == FETCH_HI_CAP) ? LH_HIGH : LH_LOW;
    assign IR_Write = cap_state && !Stall;
    assign Done     = (state == FETCH_HI_CAP) && !Stall;

endmodule

// File: tb/tb_instruction_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_sequencer
// Directed bench for the fetch sequencer. Two instances share clock and reset:
// dut1 with MEM_LATENCY=1 / RESET_PC=0 and dut3 with MEM_LATENCY=3 /
// RESET_PC=0x0010. Each has a latency-matched memory model and an
// instruction register model fed by IRByte/IR_LH/IR_Write.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset;

    logic        start1, stall1, pcload1;
    logic [15:0] pcin1;
    logic [7:0]  mem_data1;
    logic [15:0] mem_addr1, pc_out1;
    logic        mem_read1, ir_lh1, ir_write1, busy1, done1;
    logic [7:0]  ir_byte1;

    logic        start3, stall3, pcload3;
    logic [15:0] pcin3;
    logic [7:0]  mem_data3;
    logic [15:0] mem_addr3, pc_out3;
    logic        mem_read3, ir_lh3, ir_write3, busy3, done3;
    logic [7:0]  ir_byte3;
    logic [7:0]  pipe3 [3];

    logic [15:0] ir_model1 = 16'h0000;
    logic [15:0] ir_model3 = 16'h0000;
    int          write_count1 = 0;
    int          write_count3 = 0;
    int          check_count = 0;
    int          error_count = 0;
    int          wc_base;

    always #5 clock = ~clock;

    instruction_fetch_sequencer #(
        .ADDR_WIDTH(16), .RESET_PC(16'h0000), .MEM_LATENCY(1)
    ) dut1 (
        .Clock(clock), .Reset(reset), .Start(start1), .Stall(stall1),
        .PCLoad(pcload1), .PCIn(pcin1), .MemData(mem_data1),
        .MemAddr(mem_addr1), .MemRead(mem_read1), .IRByte(ir_byte1),
        .IR_LH(ir_lh1), .IR_Write(ir_write1), .Busy(busy1), .Done(done1),
        .PCOut(pc_out1)
    );

    instruction_fetch_sequencer #(
        .ADDR_WIDTH(16), .RESET_PC(16'h0010), .MEM_LATENCY(3)
    ) dut3 (
        .Clock(clock), .Reset(reset), .Start(start3), .Stall(stall3),
        .PCLoad(pcload3), .PCIn(pcin3), .MemData(mem_data3),
        .MemAddr(mem_addr3), .MemRead(mem_read3), .IRByte(ir_byte3),
        .IR_LH(ir_lh3), .IR_Write(ir_write3), .Busy(busy3), .Done(done3),
        .PCOut(pc_out3)
    );

    // Memory contents: two fixed words for the first fetch and the wrap test,
    // everything else derived from the address.
    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h34;
            16'h0001: return 8'h12;
            16'hFFFF: return 8'hCD;
            default:  return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Memory models: data appears MEM_LATENCY cycles after the address.
    always_ff @(posedge clock) begin
        mem_data1 <= mem_byte(mem_addr1);
        pipe3[0]  <= mem_byte(mem_addr3);
        pipe3[1]  <= pipe3[0];
        pipe3[2]  <= pipe3[1];
    end
    assign mem_data3 = pipe3[2];

    // Instruction register models and write counters.
    always_ff @(posedge clock) begin
        if (ir_write1) begin
            if (ir_lh1) ir_model1[15:8] <= ir_byte1;
            else        ir_model1[7:0]  <= ir_byte1;
            write_count1 <= write_count1 + 1;
        end
        if (ir_write3) begin
            if (ir_lh3) ir_model3[15:8] <= ir_byte3;
            else        ir_model3[7:0]  <= ir_byte3;
            write_count3 <= write_count3 + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drives one DUT's inputs (sel3 picks dut3) and idles the other.
    task automatic applyStimulus(input logic s, input logic st, input logic pl,
                                 input logic [15:0] pi, input logic sel3);
        start1  = sel3 ? 1'b0 : s;
        stall1  = sel3 ? 1'b0 : st;
        pcload1 = sel3 ? 1'b0 : pl;
        pcin1   = sel3 ? 16'h0 : pi;
        start3  = sel3 ? s : 1'b0;
        stall3  = sel3 ? st : 1'b0;
        pcload3 = sel3 ? pl : 1'b0;
        pcin3   = sel3 ? pi : 16'h0;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #2;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        repeat (2) @(posedge clock);
        #2;

        // Reset state
        checkOutput("rst_busy1",    32'(busy1),     32'd0);
        checkOutput("rst_memread1", 32'(mem_read1), 32'd0);
        checkOutput("rst_irwrite1", 32'(ir_write1), 32'd0);
        checkOutput("rst_done1",    32'(done1),     32'd0);
        checkOutput("rst_irbyte1",  32'(ir_byte1),  32'h0);
        checkOutput("rst_pcout1",   32'(pc_out1),   32'h0000);
        checkOutput("rst_pcout3",   32'(pc_out3),   32'h0010);
        checkOutput("rst_memaddr3", 32'(mem_addr3), 32'h0010);
        reset = 1'b0;

        // Basic fetch, latency 1
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("t1_c0_busy", 32'(busy1), 32'd0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("t1_c1_busy",    32'(busy1),     32'd1);
        checkOutput("t1_c1_memread", 32'(mem_read1), 32'd1);
        checkOutput("t1_c1_irwrite", 32'(ir_write1), 32'd0);
        checkOutput("t1_c1_memaddr", 32'(mem_addr1), 32'h0000);
        next_cycle();
        checkOutput("t1_c2_irwrite", 32'(ir_write1), 32'd1);
        checkOutput("t1_c2_irlh",    32'(ir_lh1),    32'd0);
        checkOutput("t1_c2_irbyte",  32'(ir_byte1),  32'h34);
        checkOutput("t1_c2_done",    32'(done1),     32'd0);
        next_cycle();
        checkOutput("t1_c3_irwrite", 32'(ir_write1), 32'd0);
        checkOutput("t1_c3_memaddr", 32'(mem_addr1), 32'h0001);
        next_cycle();
        checkOutput("t1_c4_irwrite", 32'(ir_write1), 32'd1);
        checkOutput("t1_c4_irlh",    32'(ir_lh1),    32'd1);
        checkOutput("t1_c4_irbyte",  32'(ir_byte1),  32'h12);
        checkOutput("t1_c4_done",    32'(done1),     32'd1);
        next_cycle();
        checkOutput("t1_c5_busy",  32'(busy1),     32'd0);
        checkOutput("t1_c5_done",  32'(done1),     32'd0);
        checkOutput("t1_c5_pcout", 32'(pc_out1),   32'h0002);
        checkOutput("t1_ir",       32'(ir_model1), 32'h1234);

        // PCLoad with Start, PC wrap from 0xFFFF
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("t2_c1_memaddr", 32'(mem_addr1), 32'hFFFF);
        next_cycle();
        checkOutput("t2_c2_irbyte", 32'(ir_byte1), 32'hCD);
        next_cycle();
        checkOutput("t2_c3_memaddr", 32'(mem_addr1), 32'h0000);
        next_cycle();
        checkOutput("t2_c4_irbyte", 32'(ir_byte1), 32'h34);
        checkOutput("t2_c4_done",   32'(done1),    32'd1);
        next_cycle();
        checkOutput("t2_c5_pcout", 32'(pc_out1),   32'h0001);
        checkOutput("t2_c5_busy",  32'(busy1),     32'd0);
        checkOutput("t2_ir",       32'(ir_model1), 32'h34CD);

        // Start held high: back-to-back fetches from address 0
        wc_base = write_count1;
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b1, 16'h0000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            next_cycle(); applyStimulus((c < 12), 1'b0, 1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("t3_c%0d_busy", c), 32'(busy1), 32'd1);
            checkOutput($sformatf("t3_c%0d_done", c), 32'(done1), 32'((c % 4) == 0));
            checkOutput($sformatf("t3_c%0d_memaddr", c), 32'(mem_addr1), 32'((c - 1) / 2));
        end
        next_cycle();
        checkOutput("t3_end_busy",   32'(busy1),                  32'd0);
        checkOutput("t3_end_pcout",  32'(pc_out1),                32'h0006);
        checkOutput("t3_end_writes", 32'(write_count1 - wc_base), 32'd6);

        // Stall for 3 cycles during LO_CAP, PC=6
        wc_base = write_count1;
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        for (int c = 2; c <= 4; c++) begin
            next_cycle(); applyStimulus(1'b0, 1'b1, 1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("t4_c%0d_irwrite", c), 32'(ir_write1), 32'd0);
            checkOutput($sformatf("t4_c%0d_pcout", c),   32'(pc_out1),   32'h0006);
            checkOutput($sformatf("t4_c%0d_memread", c), 32'(mem_read1), 32'd1);
        end
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        checkOutput("t4_c5_irwrite", 32'(ir_write1), 32'd1);
        checkOutput("t4_c5_irlh",    32'(ir_lh1),    32'd0);
        checkOutput("t4_c5_irbyte",  32'(ir_byte1),  32'h5C);
        next_cycle();
        checkOutput("t4_c6_irwrite", 32'(ir_write1),              32'd0);
        checkOutput("t4_c6_lowwr",   32'(write_count1 - wc_base), 32'd1);
        next_cycle();
        checkOutput("t4_c7_done",   32'(done1),    32'd1);
        checkOutput("t4_c7_irbyte", 32'(ir_byte1), 32'h5D);
        next_cycle();
        checkOutput("t4_c8_busy",   32'(busy1),                  32'd0);
        checkOutput("t4_c8_pcout",  32'(pc_out1),                32'h0008);
        checkOutput("t4_ir",        32'(ir_model1),              32'h5D5C);
        checkOutput("t4_writes",    32'(write_count1 - wc_base), 32'd2);

        // Async reset between low and high writes
        wc_base = write_count1;
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
        next_cycle();
        checkOutput("t5_c2_irwrite", 32'(ir_write1), 32'd1);
        next_cycle();
        checkOutput("t5_c3_busy", 32'(busy1), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("t5_rst_busy",    32'(busy1),     32'd0);
        checkOutput("t5_rst_memread", 32'(mem_read1), 32'd0);
        checkOutput("t5_rst_pcout",   32'(pc_out1),   32'h0000);
        checkOutput("t5_rst_memaddr", 32'(mem_addr1), 32'h0000);
        checkOutput("t5_rst_irbyte",  32'(ir_byte1),  32'h0);
        #1;
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
            checkOutput($sformatf("t5_post%0d_irwrite", c), 32'(ir_write1), 32'd0);
            checkOutput($sformatf("t5_post%0d_busy", c),    32'(busy1),     32'd0);
        end
        checkOutput("t5_writes", 32'(write_count1 - wc_base), 32'd1);

        // Latency 3, Start/PCLoad mid-fetch ignored, RESET_PC=0x0010
        wc_base = write_count3;
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("t6_c1_memread", 32'(mem_read3), 32'd1);
        checkOutput("t6_c1_memaddr", 32'(mem_addr3), 32'h0010);
        checkOutput("t6_c1_irwrite", 32'(ir_write3), 32'd0);
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        checkOutput("t6_c2_memread", 32'(mem_read3), 32'd1);
        checkOutput("t6_c2_irwrite", 32'(ir_write3), 32'd0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("t6_c3_memread", 32'(mem_read3), 32'd1);
        checkOutput("t6_c3_irwrite", 32'(ir_write3), 32'd0);
        checkOutput("t6_c3_memaddr", 32'(mem_addr3), 32'h0010);
        next_cycle();
        checkOutput("t6_c4_irwrite", 32'(ir_write3), 32'd1);
        checkOutput("t6_c4_irlh",    32'(ir_lh3),    32'd0);
        checkOutput("t6_c4_irbyte",  32'(ir_byte3),  32'h4A);
        next_cycle();
        checkOutput("t6_c5_memaddr", 32'(mem_addr3), 32'h0011);
        checkOutput("t6_c5_irwrite", 32'(ir_write3), 32'd0);
        next_cycle(); applyStimulus(1'b1, 1'b0, 1'b1, 16'h5555, 1'b1);
        checkOutput("t6_c6_irwrite", 32'(ir_write3), 32'd0);
        next_cycle(); applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
        checkOutput("t6_c7_irwrite", 32'(ir_write3), 32'd0);
        checkOutput("t6_c7_done",    32'(done3),     32'd0);
        next_cycle();
        checkOutput("t6_c8_done",   32'(done3),    32'd1);
        checkOutput("t6_c8_irlh",   32'(ir_lh3),   32'd1);
        checkOutput("t6_c8_irbyte", 32'(ir_byte3), 32'h4B);
        next_cycle();
        checkOutput("t6_c9_busy",   32'(busy3),                  32'd0);
        checkOutput("t6_c9_pcout",  32'(pc_out3),                32'h0012);
        checkOutput("t6_ir",        32'(ir_model3),              32'h4B4A);
        checkOutput("t6_writes",    32'(write_count3 - wc_base), 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
